// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: Avalon-MM write sequencer that reprograms the SDRAM-clock PLL, pulses its reset and waits for lock.
//   CLK_50M, RESET           : clock and synchronous active-high reset
//   req, m_val/k_val/c0_val  : start request and counter words (latched on accept)
//   busy, done, error        : sequence in progress, lock achieved pulse, lock timeout pulse
//   locked                   : raw PLL lock (asynchronous)
//   mgmt_*                   : Avalon-MM master toward pll_cfg
//   pll_reset                : PLL reset, active high
module pll_reconfig_seq #(
  parameter int RST_CYCLES   = 4,
  parameter int BLANK_CYCLES = 8,
  parameter int LOCK_TIMEOUT = 5000000
) (
  input  logic        CLK_50M,
  input  logic        RESET,
  input  logic        req,
  input  logic [31:0] m_val,
  input  logic [31:0] k_val,
  input  logic [31:0] c0_val,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic        locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        pll_reset
);
  localparam int CMAX = (LOCK_TIMEOUT > RST_CYCLES) ? ((LOCK_TIMEOUT > BLANK_CYCLES) ? LOCK_TIMEOUT : BLANK_CYCLES)
                                                    : ((RST_CYCLES > BLANK_CYCLES) ? RST_CYCLES : BLANK_CYCLES);
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] RST_END = CW'(RST_CYCLES - 1);
  // Outputs are registered from the next state, so the last blanking cycle is
  // already the first lock evaluation; its result shows on the following cycle.
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 2);
  localparam logic [CW-1:0] TO_END = CW'(LOCK_TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, WRITE, PRST, BLANK, WAIT_LOCK} state_t;
  state_t state, nxt;
  logic [2:0] wi, wi_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] m, k, c0;
  logic lock_meta, lock_s;
  logic done_n, error_n;
  logic [5:0] addr_n;
  logic [31:0] data_n;
  always_comb begin
    nxt = state;
    wi_n = wi;
    cnt_n = cnt + 1'b1;
    done_n = 1'b0;
    error_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (req) begin
          nxt = WRITE;
          wi_n = '0;
        end
      end
      WRITE: begin
        cnt_n = '0;
        if (mgmt_write && !mgmt_waitrequest) begin
          wi_n = wi + 3'd1;
          nxt = (wi == 3'd7) ? PRST : WRITE;
        end
      end
      PRST: if (cnt == RST_END) begin
        nxt = (BLANK_CYCLES > 1) ? BLANK : WAIT_LOCK;
        cnt_n = '0;
      end
      BLANK: if (cnt == BLANK_END) begin
        nxt = WAIT_LOCK;
        cnt_n = '0;
      end
      WAIT_LOCK: begin
        // lock takes priority over a coincident timeout
        done_n = lock_s;
        error_n = !lock_s && (cnt == TO_END);
        nxt = (done_n || error_n) ? IDLE : WAIT_LOCK;
      end
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    addr_n = '0;
    data_n = '0;
    case (wi_n)
      3'd0: {addr_n, data_n} = {6'd0, 32'd0};
      3'd1: {addr_n, data_n} = {6'd4, m};
      3'd2: {addr_n, data_n} = {6'd7, k};
      3'd3: {addr_n, data_n} = {6'd3, 32'h0001_0000};
      3'd4: {addr_n, data_n} = {6'd5, c0};
      3'd5: {addr_n, data_n} = {6'd9, 32'd1};
      3'd6: {addr_n, data_n} = {6'd8, 32'd7};
      3'd7: {addr_n, data_n} = {6'd2, 32'd0};
      default: {addr_n, data_n} = '0;
    endcase
    // the counter words are still being latched on the accept edge
    if (state == IDLE) begin
      data_n = '0;
    end
    if (nxt != WRITE) begin
      addr_n = '0;
      data_n = '0;
    end
  end
  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      state <= IDLE;
      wi <= '0;
      cnt <= '0;
      lock_meta <= 1'b0;
      lock_s <= 1'b0;
      m <= '0;
      k <= '0;
      c0 <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      mgmt_write <= 1'b0;
      mgmt_address <= '0;
      mgmt_writedata <= '0;
      pll_reset <= 1'b0;
    end else begin
      state <= nxt;
      wi <= wi_n;
      cnt <= cnt_n;
      lock_meta <= locked;
      lock_s <= lock_meta;
      if (state == IDLE && req) begin
        m <= m_val;
        k <= k_val;
        c0 <= c0_val;
      end
      busy <= nxt != IDLE;
      done <= done_n;
      error <= error_n;
      mgmt_write <= nxt == WRITE;
      mgmt_address <= addr_n;
      mgmt_writedata <= data_n;
      pll_reset <= nxt == PRST;
    end
  end
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb_pll_reconfig_seq: scoreboard bench for pll_reconfig_seq with directed request sequences.
module tb_pll_reconfig_seq;
  logic CLK_50M = 1'b0;
  logic RESET, req, locked, mgmt_waitrequest;
  logic [31:0] m_val, k_val, c0_val;
  logic busy, done, error, mgmt_write, pll_reset;
  logic [5:0] mgmt_address;
  logic [31:0] mgmt_writedata;
  pll_reconfig_seq #(.RST_CYCLES(4), .BLANK_CYCLES(8), .LOCK_TIMEOUT(100)) dut (
    .CLK_50M(CLK_50M), .RESET(RESET), .req(req), .m_val(m_val), .k_val(k_val), .c0_val(c0_val),
    .busy(busy), .done(done), .error(error), .locked(locked), .mgmt_waitrequest(mgmt_waitrequest),
    .mgmt_write(mgmt_write), .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
    .pll_reset(pll_reset)
  );
  always #10 CLK_50M = ~CLK_50M;
  int cyc = 0;
  always @(posedge CLK_50M) cyc <= cyc + 1;
  typedef struct packed {int c; logic [5:0] a; logic [31:0] d;} wr_t;
  wr_t wq[$];
  int pq_s[$], pq_l[$], rq_c[$];
  bit rq_e[$];
  int n_vec = 0, n_bad = 0;
  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  task automatic unexpected(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s at cycle %0d: event with nothing expected", nm, cyc);
  endtask
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge CLK_50M);
      #1;
    end
  endtask
  task automatic push_writes(input int t0, input logic [31:0] m, k, c0, input int sw, sn, nw);
    logic [5:0] a [8] = '{6'd0, 6'd4, 6'd7, 6'd3, 6'd5, 6'd9, 6'd8, 6'd2};
    logic [31:0] d [8];
    d = '{32'd0, m, k, 32'h0001_0000, c0, 32'd1, 32'd7, 32'd0};
    for (int i = 0; i < nw; i++)
      wq.push_back('{c: t0 + 1 + i + ((i >= sw) ? sn : 0), a: a[i], d: d[i]});
  endtask
  task automatic push_tail(input int t0, input int sn, input int res_off, input bit e);
    pq_s.push_back(t0 + 9 + sn);
    pq_l.push_back(4);
    rq_c.push_back(t0 + res_off + sn);
    rq_e.push_back(e);
  endtask
  task automatic issue_req(input int t0, input logic [31:0] m, k, c0);
    goto(t0);
    req = 1'b1;
    m_val = m;
    k_val = k;
    c0_val = c0;
    goto(t0 + 1);
    req = 1'b0;
    m_val = 32'hDEAD_BEEF;
    k_val = 32'hDEAD_BEEF;
    c0_val = 32'hDEAD_BEEF;
  endtask
  task automatic check_zero(input string nm);
    @(negedge CLK_50M);
    check(nm, {busy, done, error, mgmt_write, pll_reset, mgmt_address, mgmt_writedata}, '0);
  endtask
  logic prst_prev = 1'b0;
  int prst_start = 0;
  always @(negedge CLK_50M) begin
    if (mgmt_write && !mgmt_waitrequest) begin
      if (wq.size() == 0) unexpected("write");
      else check("write", {cyc, mgmt_address, mgmt_writedata}, wq.pop_front());
    end
    if (mgmt_write && mgmt_waitrequest && wq.size() > 0)
      check("stall hold", {mgmt_address, mgmt_writedata}, {wq[0].a, wq[0].d});
    if (done || error) begin
      if (rq_c.size() == 0) unexpected("result");
      else begin
        bit e;
        int c;
        c = rq_c.pop_front();
        e = rq_e.pop_front();
        check(e ? "timeout" : "lock", {cyc, done, error, busy}, {c, !e, e, 1'b0});
      end
    end
    if (pll_reset && !prst_prev) prst_start = cyc;
    if (!pll_reset && prst_prev) begin
      if (pq_s.size() == 0) unexpected("pll_reset");
      else check("pll_reset pulse", {prst_start, cyc - prst_start}, {pq_s.pop_front(), pq_l.pop_front()});
    end
    prst_prev <= pll_reset;
  end
  initial begin
    RESET = 1'b1;
    req = 1'b0;
    locked = 1'b1;
    mgmt_waitrequest = 1'b0;
    m_val = '0;
    k_val = '0;
    c0_val = '0;
    goto(2);
    check_zero("reset state");
    goto(3);
    RESET = 1'b0;
    // stale lock held high, no stalls, repeated req while busy
    push_writes(10, 32'h0000_0A0A, 32'h1234_5678, 32'h0002_0302, 8, 0, 8);
    push_tail(10, 0, 21, 1'b0);
    issue_req(10, 32'h0000_0A0A, 32'h1234_5678, 32'h0002_0302);
    goto(15); req = 1'b1;
    goto(16); req = 1'b0;
    goto(25); req = 1'b1;
    goto(26); req = 1'b0;
    // request right after done, three stall cycles on write 2
    push_writes(31, 32'h0000_0808, 32'hB333_32DD, 32'h0001_0101, 2, 3, 8);
    push_tail(31, 3, 21, 1'b0);
    issue_req(31, 32'h0000_0808, 32'hB333_32DD, 32'h0001_0101);
    goto(34); mgmt_waitrequest = 1'b1;
    goto(37); mgmt_waitrequest = 1'b0;
    // no lock at all: timeout
    goto(56); locked = 1'b0;
    push_writes(60, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 8, 0, 8);
    push_tail(60, 0, 120, 1'b1);
    issue_req(60, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
    // lock becomes visible in the very cycle the timeout expires
    push_writes(185, 32'h0000_0606, 32'h0000_0001, 32'h0000_0505, 8, 0, 8);
    push_tail(185, 0, 120, 1'b0);
    issue_req(185, 32'h0000_0606, 32'h0000_0001, 32'h0000_0505);
    goto(302); locked = 1'b1;
    // reset during write 4, then a clean full sequence
    push_writes(310, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 8, 0, 5);
    issue_req(310, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003);
    goto(315); RESET = 1'b1;
    goto(316); RESET = 1'b0;
    check_zero("reset mid-write");
    push_writes(318, 32'h5555_0001, 32'h5555_0002, 32'h5555_0003, 8, 0, 8);
    push_tail(318, 0, 21, 1'b0);
    issue_req(318, 32'h5555_0001, 32'h5555_0002, 32'h5555_0003);
    // reset during the pll_reset pulse truncates it to two cycles
    push_writes(341, 32'h0BAD_0001, 32'h0BAD_0002, 32'h0BAD_0003, 8, 0, 8);
    pq_s.push_back(350);
    pq_l.push_back(2);
    issue_req(341, 32'h0BAD_0001, 32'h0BAD_0002, 32'h0BAD_0003);
    goto(351); RESET = 1'b1;
    goto(352); RESET = 1'b0;
    check_zero("reset mid-prst");
    push_writes(354, 32'h7777_0001, 32'h7777_0002, 32'h7777_0003, 8, 0, 8);
    push_tail(354, 0, 21, 1'b0);
    issue_req(354, 32'h7777_0001, 32'h7777_0002, 32'h7777_0003);
    goto(390);
    check("writes outstanding", 96'(wq.size()), 96'd0);
    check("pll_reset outstanding", 96'(pq_s.size()), 96'd0);
    check("results outstanding", 96'(rq_c.size()), 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pll_reconfig_seq.md
# pll_reconfig_seq

Avalon-MM write sequencer for the SDRAM-clock PLL in the memory tester. Sits between the frequency/test control logic and the `pll_cfg` reconfiguration core. On a single request it:

- writes the M, K and C0 words plus the fixed N, charge-pump and bandwidth settings;
- triggers the apply write;
- pulses the PLL reset;
- waits for lock, then reports completion or timeout.

## Interface

Parameters:
- `RST_CYCLES`, default 4: number of cycles `pll_reset` is held high after the apply write.
- `BLANK_CYCLES`, default 8: cycles after `pll_reset` falls during which `locked` is ignored.
- `LOCK_TIMEOUT`, default 5000000: maximum cycles to wait for lock (100 ms at 50 MHz).

Ports:
- `CLK_50M`  in  1  system clock; all logic in this domain.
- `RESET`  in  1  synchronous, active-high reset.
- `req`  in  1  start request; sampled only when `busy`=0.
- `m_val`  in  32  M counter word; latched on request accept.
- `k_val`  in  32  fractional K word; latched on accept.
- `c0_val`  in  32  C0 counter word; latched on accept.
- `busy`  out  1  high from the cycle after accept until completion.
- `done`  out  1  one-cycle pulse: lock achieved.
- `error`  out  1  one-cycle pulse: lock timeout.
- `locked`  in  1  PLL lock; asynchronous, 2-flop synchronized internally.
- `mgmt_waitrequest`  in  1  `pll_cfg` stall.
- `mgmt_write`  out  1  Avalon write strobe.
- `mgmt_address`  out  6  register address.
- `mgmt_writedata`  out  32  register data.
- `pll_reset`  out  1  PLL reset, active high.

## Operation

- States are `IDLE`, `WRITE`, `PRST`, `BLANK`, `WAIT_LOCK`.
- `IDLE`:
  - `req`=1 latches `m_val`/`k_val`/`c0_val`, clears the write index `wi` (3 bits) and goes to `WRITE`.
  - `req` while `busy` is ignored; no queuing.
- Write table, indexed by `wi`, as (address, data):
  - 0: (0, 0) mode.
  - 1: (4, M).
  - 2: (7, K).
  - 3: (3, 0x10000) N bypass.
  - 4: (5, C0).
  - 5: (9, 1) charge pump.
  - 6: (8, 7) bandwidth.
  - 7: (2, 0) apply.
- `WRITE`:
  - `mgmt_write`=1 with the address/data of table entry `wi`.
  - A write completes in a cycle where `mgmt_write`=1 and `mgmt_waitrequest`=0.
  - On completion, `wi` increments and the next write is presented the following cycle (back-to-back).
  - Address and data are held stable while stalled.
  - After entry 7 completes, go to `PRST`.
  - No write timeout. A stuck `waitrequest` holds the block in `WRITE` until `RESET`.
- `PRST`: `pll_reset`=1 for exactly `RST_CYCLES` cycles, then `BLANK`.
- `BLANK`: `pll_reset`=0. Wait `BLANK_CYCLES` cycles so a stale synchronized `locked`=1 is not taken as lock. Then `WAIT_LOCK` with the timeout counter cleared.
- `WAIT_LOCK`:
  - Synchronized `locked`=1 → `done` pulse, `busy`=0, return to `IDLE`.
  - Counter reaching `LOCK_TIMEOUT-1` without lock → `error` pulse, `busy`=0, return to `IDLE`.
  - If lock and timeout occur in the same cycle, lock wins: `done`, not `error`.
- Counter widths are `$clog2(param+1)`. No wrap-around is possible because each counter is cleared on state entry.
- `RESET` at any time (mid-write included):
  - state goes to `IDLE`; `wi` and counters go to 0; synchronizer flops go to 0;
  - all outputs go low next edge, including a `pll_reset` that was mid-pulse.
  - An aborted write sequence is not resumed.
- Reset values: `busy`=0, `done`=0, `error`=0, `mgmt_write`=0, `mgmt_address`=0, `mgmt_writedata`=0, `pll_reset`=0.

## Timing

- Cycle numbering below is for the no-stall case (`mgmt_waitrequest`=0).
- `req` sampled high at cycle 0 → `busy`=1 and write 0 presented at cycle 1. Writes 0..7 occupy cycles 1..8.
- `pll_reset` is high on cycles 9..8+`RST_CYCLES` (default 9..12).
- `BLANK` occupies the next `BLANK_CYCLES` cycles (default 13..20).
- `locked` is first evaluated at cycle 9+`RST_CYCLES`+`BLANK_CYCLES` (default 21).
- The synchronizer adds 2 cycles of latency from a raw `locked` edge.
- `done`/`error` are asserted in the same cycle `busy` falls. A new `req` is accepted in the next cycle.
- Each stall cycle on a write delays everything after it by one cycle.
- All outputs are registered.

## Test plan

- No stalls, default params, `locked` held 1 throughout → eight writes on cycles 1–8 with addresses 0,4,7,3,5,9,8,2 and the correct data; `pll_reset` on cycles 9–12; `done` at cycle 21. Checks that the blanking window hides the stale lock.
- `mgmt_waitrequest` high for 3 cycles during write 2 (K=0xB33332DD) → address 7 and data 0xB33332DD held for 4 cycles; `done` delayed by exactly 3 cycles.
- `locked` forced 0 with `LOCK_TIMEOUT`=100 → `error` pulse at cycle 21+99; no `done`; `busy`=0 in the same cycle.
- `req` repulsed at cycles 5 and 15 during the sequence → ignored: no restart and write count stays 8. `req` the cycle after `done` → a new sequence starts.
- `RESET` asserted during write 4, and separately during `PRST` → all outputs 0 next cycle; `pll_reset` pulse truncated; the following `req` runs a full clean sequence from write 0.
- `locked` rises in the same cycle the timeout expires → `done`=1, `error`=0.
